dpram_arbiter: RTL and testbench
================================

DPRAM_ARBITER -- requirements
Module: dpram_arbiter

Interface
REQ-001 SHALL have parameter AW, default 3, address width of each RAM bank.
REQ-002 SHALL have parameter DW, default 3, data width of each RAM bank.
REQ-003 SHALL have parameter MAX_BURST, default 4, maximum consecutive grants to one owner (used only under ARB_BURST_EN).
REQ-004 SHALL have port clk  input  1  single clock, all state updates on posedge.
REQ-005 SHALL have port rst_n  input  1  reset, synchronous, active-low.
REQ-006 SHALL have ports a_req/b_req  input  1  access request from requester A/B.
REQ-007 SHALL have ports a_we/b_we  input  1  1=write, 0=read, qualified by req.
REQ-008 SHALL have ports a_addr/b_addr  input  AW  access address.
REQ-009 SHALL have ports a_wdata/b_wdata  input  DW  write data.
REQ-010 SHALL have ports a_gnt/b_gnt  output  1  access accepted this cycle.
REQ-011 SHALL have ports a_rdata/b_rdata  output  DW  read data, valid with rvalid.
REQ-012 SHALL have ports a_rvalid/b_rvalid  output  1  read-data strobe, one cycle.
REQ-013 SHALL have ports ram_cs, ram_we  output  1  RAM bank select (1=bank A, 0=bank B) and write enable.
REQ-014 SHALL have ports ram_addr_a/ram_addr_b  output  AW, and ram_data_a/ram_data_b  output  DW, driving the RAM.
REQ-015 SHALL have ports ram_data_aout/ram_data_bout  input  DW  registered RAM read data.

Function
REQ-016 SHALL map requester A exclusively to bank A and requester B exclusively to bank B; exactly one bank accessed per cycle.
REQ-017 SHALL implement FSM states IDLE, OWN_A, OWN_B; state = owner of the previous cycle's grant, IDLE if none.
REQ-018 SHALL compute gnt combinationally in the request cycle; the RAM access occurs at the closing clock edge of that cycle.
REQ-019 SHALL, when neither req, assert no gnt, drive ram_we=0, hold ram_cs at its last value, next state IDLE.
REQ-020 SHALL, when exactly one req, grant that requester.
REQ-021 SHALL, when both req, grant the requester not granted most recently (round-robin pointer); the pointer resets to "last=B", so A wins the first tie.
REQ-022 SHALL, while a gnt is asserted, drive ram_cs, ram_we and that bank's address/data from the winner; the other bank's address/data SHALL be 0.
REQ-023 SHALL assert x_rvalid exactly one cycle after a granted read (we=0), with x_rdata = ram_data_xout; x_rdata SHALL be 0 when x_rvalid=0.
REQ-024 SHALL never assert rvalid for a granted write.
REQ-025 SHALL sustain one grant per cycle; back-to-back reads by alternating owners SHALL each return data on the following cycle.
REQ-026 SHALL allow a requester to change addr/we/wdata every granted cycle; a requester that is not granted SHALL hold its request until gnt.

Reset
REQ-027 SHALL, while rst_n=0 at a clock edge, set state=IDLE, pointer=last B, burst count=0, a/b_rvalid=0, ram_cs=1, ram_we=0, gnt outputs 0.
REQ-028 SHALL drop any read granted in the cycle rst_n is asserted; no rvalid after reset.

Configuration
REQ-029 SHALL use macro DPRAM_ARB_BURST_EN: when defined, on a tie the current owner keeps the grant until it has received MAX_BURST consecutive grants, then yields; counter clears on owner change or idle cycle.
REQ-030 SHALL, without DPRAM_ARB_BURST_EN, alternate strictly on every tie and contain no burst counter.

Structure
REQ-031 SHALL place the FSM state enum and default AW/DW/MAX_BURST constants in package dpram_arb_pkg.
REQ-032 SHALL contain one sub-module, dpram_rr_pick, computing the 2-way round-robin winner from req pair, pointer and (optional) burst-hold input.

Verification
REQ-033 SHALL cover: reset, then A write addr 3 data 5, then A read addr 3 -> a_rvalid one cycle after read grant, a_rdata=5.
REQ-034 SHALL cover: a_req and b_req both held 4 cycles, macro off -> gnt order A,B,A,B.
REQ-035 SHALL cover: both held 6 cycles, DPRAM_ARB_BURST_EN, MAX_BURST=4 -> A,A,A,A,B,B.
REQ-036 SHALL cover: B writes addr 2 data 7 then A reads addr 2 -> A receives bank-A content (not 7), confirming bank isolation.
REQ-037 SHALL cover: rst_n low in a read-grant cycle -> no rvalid next cycle, state IDLE, next tie granted to A.
REQ-038 SHALL cover: no requests for 3 cycles -> ram_we=0, no gnt, no rvalid throughout.

Source files
------------

// File: rtl/dpram_arb_pkg.sv
// -----------------------------------------------------------------------------
// dpram_arb_pkg
// Shared definitions for the dual-bank RAM arbiter:
//   - default AW / DW / MAX_BURST values
//   - arb_state_e : owner of the previous cycle's grant (IDLE if none)
//   - cnt_width() : width of a counter that can hold 0..max_val
// -----------------------------------------------------------------------------
package dpram_arb_pkg;

  localparam int DEF_AW        = 3;
  localparam int DEF_DW        = 3;
  localparam int DEF_MAX_BURST = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    OWN_A = 2'd1,
    OWN_B = 2'd2
  } arb_state_e;

  function automatic int cnt_width(input int max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/dpram_arbiter_if.sv
// -----------------------------------------------------------------------------
// dpram_arbiter_if
// Bundles the requester A/B handshakes and the RAM-side bus.
//   Requester side : a/b_req, a/b_we, a/b_addr, a/b_wdata  -> arbiter
//                    a/b_gnt, a/b_rdata, a/b_rvalid        <- arbiter
//   RAM side       : ram_cs (1=bank A), ram_we, ram_addr_a/b, ram_data_a/b
//                                                          <- arbiter
//                    ram_data_aout/bout (registered read)  -> arbiter
// Modports:
//   slave  : the arbiter
//   master : the environment (requesters plus RAM banks)
// -----------------------------------------------------------------------------
interface dpram_arbiter_if #(
  parameter int AW = dpram_arb_pkg::DEF_AW,
  parameter int DW = dpram_arb_pkg::DEF_DW
);

  logic          a_req,  b_req;
  logic          a_we,   b_we;
  logic [AW-1:0] a_addr, b_addr;
  logic [DW-1:0] a_wdata, b_wdata;
  logic          a_gnt,  b_gnt;
  logic [DW-1:0] a_rdata, b_rdata;
  logic          a_rvalid, b_rvalid;

  logic          ram_cs;
  logic          ram_we;
  logic [AW-1:0] ram_addr_a, ram_addr_b;
  logic [DW-1:0] ram_data_a, ram_data_b;
  logic [DW-1:0] ram_data_aout, ram_data_bout;

  modport slave (
    input  a_req, b_req, a_we, b_we, a_addr, b_addr, a_wdata, b_wdata,
    input  ram_data_aout, ram_data_bout,
    output a_gnt, b_gnt, a_rdata, b_rdata, a_rvalid, b_rvalid,
    output ram_cs, ram_we, ram_addr_a, ram_addr_b, ram_data_a, ram_data_b
  );

  modport master (
    output a_req, b_req, a_we, b_we, a_addr, b_addr, a_wdata, b_wdata,
    output ram_data_aout, ram_data_bout,
    input  a_gnt, b_gnt, a_rdata, b_rdata, a_rvalid, b_rvalid,
    input  ram_cs, ram_we, ram_addr_a, ram_addr_b, ram_data_a, ram_data_b
  );

endinterface

// File: rtl/dpram_rr_pick.sv
// -----------------------------------------------------------------------------
// dpram_rr_pick
// Two-way round-robin winner select (purely combinational).
//   i_req_a / i_req_b : requests
//   i_last_b          : 1 = B was granted most recently
//   i_hold            : on a tie, keep the most recent owner instead of
//                       alternating (burst continuation)
//   o_gnt_a / o_gnt_b : one-hot (or zero) grant
// -----------------------------------------------------------------------------
module dpram_rr_pick (
  input  logic i_req_a,
  input  logic i_req_b,
  input  logic i_last_b,
  input  logic i_hold,
  output logic o_gnt_a,
  output logic o_gnt_b
);

  // On a tie B wins when it is "the other one" (last was A) or when the
  // most recent owner B is allowed to hold.
  logic w_tie_pick_b;
  assign w_tie_pick_b = i_hold ? i_last_b : ~i_last_b;

  assign o_gnt_a = i_req_a & (~i_req_b | ~w_tie_pick_b);
  assign o_gnt_b = i_req_b & (~i_req_a |  w_tie_pick_b);

endmodule

// File: rtl/dpram_arbiter.sv
// -----------------------------------------------------------------------------
// dpram_arbiter
// Arbitrates two requesters onto a two-bank RAM; requester A always uses
// bank A, requester B always uses bank B, and one bank is accessed per cycle.
// Grants are combinational in the request cycle; the RAM access happens on
// the closing clock edge. Read data returns one cycle later with x_rvalid.
//
// Ports:
//   clk   : clock, all state on posedge
//   rst_n : synchronous active-low reset
//   bus   : dpram_arbiter_if.slave (requester handshakes + RAM bus)
//
// Parameters: AW, DW (bank address/data width), MAX_BURST (tie hold limit).
//
// Build option: define DPRAM_ARB_BURST_EN to let the current owner keep the
// grant on ties for up to MAX_BURST consecutive grants. Without it ties
// alternate strictly and no burst counter exists.
// -----------------------------------------------------------------------------
module dpram_arbiter
  import dpram_arb_pkg::*;
#(
  parameter int AW        = DEF_AW,
  parameter int DW        = DEF_DW,
  parameter int MAX_BURST = DEF_MAX_BURST
) (
  input  logic            clk,
  input  logic            rst_n,
  dpram_arbiter_if.slave  bus
);

  if (MAX_BURST < 1) begin : g_bad_max_burst
    $error("dpram_arbiter: MAX_BURST must be at least 1");
  end

  arb_state_e r_state;
  logic       r_last_b;     // round-robin pointer: 1 = B granted most recently
  logic       r_ram_cs;     // bank select held through idle cycles
  logic       r_a_rvalid;
  logic       r_b_rvalid;

  logic       w_gnt_a;
  logic       w_gnt_b;
  logic       w_hold;
  logic       w_burst_ok;

`ifdef DPRAM_ARB_BURST_EN
  localparam int            CW = cnt_width(MAX_BURST);
  localparam logic [CW-1:0] MB = CW'(MAX_BURST);

  logic [CW-1:0] r_burst_cnt;   // consecutive grants to the current owner
  logic [CW-1:0] w_cnt_inc;

  // Saturate so a long solo run cannot wrap and re-open the hold window.
  assign w_cnt_inc  = (r_burst_cnt < MB) ? r_burst_cnt + CW'(1) : r_burst_cnt;
  assign w_burst_ok = (r_burst_cnt < MB);
`else
  assign w_burst_ok = 1'b0;
`endif

  // Only a live owner (granted last cycle) may hold on a tie.
  assign w_hold = (r_state != IDLE) & w_burst_ok;

  dpram_rr_pick u_pick (
    .i_req_a  (bus.a_req),
    .i_req_b  (bus.b_req),
    .i_last_b (r_last_b),
    .i_hold   (w_hold),
    .o_gnt_a  (w_gnt_a),
    .o_gnt_b  (w_gnt_b)
  );

  assign bus.a_gnt = w_gnt_a;
  assign bus.b_gnt = w_gnt_b;

  // RAM drive: winner's bank gets address/data, the other bank is zeroed.
  assign bus.ram_cs     = w_gnt_a ? 1'b1 : (w_gnt_b ? 1'b0 : r_ram_cs);
  assign bus.ram_we     = (w_gnt_a & bus.a_we) | (w_gnt_b & bus.b_we);
  assign bus.ram_addr_a = w_gnt_a ? bus.a_addr  : {AW{1'b0}};
  assign bus.ram_addr_b = w_gnt_b ? bus.b_addr  : {AW{1'b0}};
  assign bus.ram_data_a = w_gnt_a ? bus.a_wdata : {DW{1'b0}};
  assign bus.ram_data_b = w_gnt_b ? bus.b_wdata : {DW{1'b0}};

  // The RAM output register already holds the read result in the cycle
  // after the access, so only the strobe needs to be registered here.
  assign bus.a_rvalid = r_a_rvalid;
  assign bus.b_rvalid = r_b_rvalid;
  assign bus.a_rdata  = r_a_rvalid ? bus.ram_data_aout : {DW{1'b0}};
  assign bus.b_rdata  = r_b_rvalid ? bus.ram_data_bout : {DW{1'b0}};

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_last_b   <= 1'b1;
      r_ram_cs   <= 1'b1;
      r_a_rvalid <= 1'b0;
      r_b_rvalid <= 1'b0;
`ifdef DPRAM_ARB_BURST_EN
      r_burst_cnt <= '0;
`endif
    end else begin
      r_a_rvalid <= w_gnt_a & ~bus.a_we;
      r_b_rvalid <= w_gnt_b & ~bus.b_we;
      if (w_gnt_a) begin
        r_state  <= OWN_A;
        r_last_b <= 1'b0;
        r_ram_cs <= 1'b1;
`ifdef DPRAM_ARB_BURST_EN
        r_burst_cnt <= (r_state == OWN_A) ? w_cnt_inc : CW'(1);
`endif
      end else if (w_gnt_b) begin
        r_state  <= OWN_B;
        r_last_b <= 1'b1;
        r_ram_cs <= 1'b0;
`ifdef DPRAM_ARB_BURST_EN
        r_burst_cnt <= (r_state == OWN_B) ? w_cnt_inc : CW'(1);
`endif
      end else begin
        r_state <= IDLE;
`ifdef DPRAM_ARB_BURST_EN
        r_burst_cnt <= '0;
`endif
      end
    end
  end

endmodule

// File: tb/tb_dpram_arbiter.sv
// -----------------------------------------------------------------------------
// tb_dpram_arbiter
// Directed stimulus against dpram_arbiter with a two-bank RAM model, a
// behavioural reference model checked every cycle, and literal expectations
// for the key scenarios. Honors DPRAM_ARB_BURST_EN for tie ordering.
// -----------------------------------------------------------------------------
module tb_dpram_arbiter;
  import dpram_arb_pkg::*;

  localparam int AW   = 3;
  localparam int DW   = 3;
  localparam int MAXB = 4;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  dpram_arbiter_if #(.AW(AW), .DW(DW)) bus ();

  dpram_arbiter #(.AW(AW), .DW(DW), .MAX_BURST(MAXB)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  int n_tests = 0;
  int n_fail  = 0;
  bit started = 1'b0;

  task automatic chk(input string nm, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- RAM banks (registered read, read-first) ----------------
  logic [DW-1:0] ram_a [8] = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7};
  logic [DW-1:0] ram_b [8] = '{3'd7, 3'd6, 3'd5, 3'd4, 3'd3, 3'd2, 3'd1, 3'd0};
  logic [DW-1:0] aout = '0;
  logic [DW-1:0] bout = '0;
  assign bus.ram_data_aout = aout;
  assign bus.ram_data_bout = bout;

  always @(posedge clk) begin
    if (bus.ram_cs) begin
      if (bus.ram_we) ram_a[bus.ram_addr_a] <= bus.ram_data_a;
      aout <= ram_a[bus.ram_addr_a];
    end else begin
      if (bus.ram_we) ram_b[bus.ram_addr_b] <= bus.ram_data_b;
      bout <= ram_b[bus.ram_addr_b];
    end
  end

  // ---------------- reference model ----------------
  // Owner codes: 0 = none, 1 = A, 2 = B.
  int  m_last = 2;          // most recently granted requester
  int  m_prev = 0;          // owner of previous cycle
  int  m_run  = 0;          // consecutive grants to m_prev
  bit  m_cs   = 1'b1;       // bank shown on ram_cs when idle
  bit  m_pend_a = 1'b0, m_pend_b = 1'b0;
  int  m_pdata_a = 0, m_pdata_b = 0;
  int  mA [8] = '{0, 1, 2, 3, 4, 5, 6, 7};
  int  mB [8] = '{7, 6, 5, 4, 3, 2, 1, 0};

  function automatic int pick(input bit ra, input bit rb);
    if (!ra && !rb) return 0;
    if (ra && !rb)  return 1;
    if (rb && !ra)  return 2;
`ifdef DPRAM_ARB_BURST_EN
    if (m_prev != 0 && m_run < MAXB) return m_prev;
`endif
    return (m_last == 2) ? 1 : 2;
  endfunction

  always @(posedge clk) begin
    int w;
    w = pick(bus.a_req, bus.b_req);
    if (w == 1) begin
      m_pdata_a = mA[bus.a_addr];
      if (bus.a_we) mA[bus.a_addr] = int'(bus.a_wdata);
    end
    if (w == 2) begin
      m_pdata_b = mB[bus.b_addr];
      if (bus.b_we) mB[bus.b_addr] = int'(bus.b_wdata);
    end
    if (!rst_n) begin
      m_last = 2; m_prev = 0; m_run = 0; m_cs = 1'b1;
      m_pend_a = 1'b0; m_pend_b = 1'b0;
    end else begin
      m_pend_a = (w == 1) && !bus.a_we;
      m_pend_b = (w == 2) && !bus.b_we;
      if (w == 0) begin
        m_prev = 0; m_run = 0;
      end else begin
        m_run  = (w == m_prev) ? m_run + 1 : 1;
        m_prev = w;
        m_last = w;
        m_cs   = (w == 1);
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    int w;
    if (started) begin
      w = pick(bus.a_req, bus.b_req);
      chk("a_rvalid", int'(bus.a_rvalid), int'(m_pend_a));
      chk("b_rvalid", int'(bus.b_rvalid), int'(m_pend_b));
      chk("a_rdata",  int'(bus.a_rdata),  m_pend_a ? m_pdata_a : 0);
      chk("b_rdata",  int'(bus.b_rdata),  m_pend_b ? m_pdata_b : 0);
      if (rst_n) begin
        chk("a_gnt",  int'(bus.a_gnt),  int'(w == 1));
        chk("b_gnt",  int'(bus.b_gnt),  int'(w == 2));
        chk("ram_cs", int'(bus.ram_cs), (w == 1) ? 1 : (w == 2) ? 0 : int'(m_cs));
        chk("ram_we", int'(bus.ram_we),
            (w == 1) ? int'(bus.a_we) : (w == 2) ? int'(bus.b_we) : 0);
        chk("ram_addr_a", int'(bus.ram_addr_a), (w == 1) ? int'(bus.a_addr)  : 0);
        chk("ram_addr_b", int'(bus.ram_addr_b), (w == 2) ? int'(bus.b_addr)  : 0);
        chk("ram_data_a", int'(bus.ram_data_a), (w == 1) ? int'(bus.a_wdata) : 0);
        chk("ram_data_b", int'(bus.ram_data_b), (w == 2) ? int'(bus.b_wdata) : 0);
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic drive(input bit ar, input bit aw, input int aa, input int ad,
                       input bit br, input bit bw, input int ba, input int bd);
    bus.a_req = ar; bus.a_we = aw; bus.a_addr = AW'(aa); bus.a_wdata = DW'(ad);
    bus.b_req = br; bus.b_we = bw; bus.b_addr = AW'(ba); bus.b_wdata = DW'(bd);
  endtask

  task automatic idle();
    drive(0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic next();
    @(posedge clk);
    #1;
  endtask

  int exp_seq [6];

  initial begin
`ifdef DPRAM_ARB_BURST_EN
    exp_seq = '{1, 1, 1, 1, 2, 2};
`else
    exp_seq = '{1, 2, 1, 2, 1, 2};
`endif
    idle();
    rst_n = 1'b0;
    @(posedge clk);
    started = 1'b1;
    #1;
    next();
    rst_n = 1'b1;

    // Reset state, then three idle cycles
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("idle_a_gnt",    int'(bus.a_gnt),    0);
      chk("idle_b_gnt",    int'(bus.b_gnt),    0);
      chk("idle_ram_we",   int'(bus.ram_we),   0);
      chk("idle_a_rvalid", int'(bus.a_rvalid), 0);
      chk("idle_b_rvalid", int'(bus.b_rvalid), 0);
      if (i == 0) chk("reset_ram_cs", int'(bus.ram_cs), 1);
      next();
    end

    // Tie held 6 cycles (reads to addr 1 of each bank)
    drive(1, 0, 1, 0, 1, 0, 1, 0);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("tie_a_gnt", int'(bus.a_gnt), int'(exp_seq[i] == 1));
      chk("tie_b_gnt", int'(bus.b_gnt), int'(exp_seq[i] == 2));
      next();
    end
    idle();
    next();

    // A write addr 3 = 5, then A read addr 3
    drive(1, 1, 3, 5, 0, 0, 0, 0);
    @(negedge clk);
    chk("wr_a_gnt", int'(bus.a_gnt), 1);
    next();
    drive(1, 0, 3, 0, 0, 0, 0, 0);
    @(negedge clk);
    chk("wr_no_rvalid", int'(bus.a_rvalid), 0);
    chk("rd_a_gnt", int'(bus.a_gnt), 1);
    next();
    idle();
    @(negedge clk);
    chk("rd_a_rvalid", int'(bus.a_rvalid), 1);
    chk("rd_a_rdata",  int'(bus.a_rdata),  5);
    next();

    // Bank isolation: B writes addr 2 = 7, A reads addr 2 -> bank A's 2
    drive(0, 0, 0, 0, 1, 1, 2, 7);
    next();
    drive(1, 0, 2, 0, 0, 0, 0, 0);
    next();
    idle();
    @(negedge clk);
    chk("iso_a_rvalid", int'(bus.a_rvalid), 1);
    chk("iso_a_rdata",  int'(bus.a_rdata),  2);
    next();

    // Reset during an A read grant (A was granted last, so only a reset
    // pointer lets A win the following tie)
    rst_n = 1'b0;
    drive(1, 0, 4, 0, 0, 0, 0, 0);
    next();
    rst_n = 1'b1;
    idle();
    @(negedge clk);
    chk("rst_no_rvalid", int'(bus.a_rvalid), 0);
    next();
    drive(1, 0, 1, 0, 1, 0, 1, 0);
    @(negedge clk);
    chk("rst_tie_a_gnt", int'(bus.a_gnt), 1);
    chk("rst_tie_b_gnt", int'(bus.b_gnt), 0);
    next();
    idle();
    next();

    // Back-to-back reads by alternating owners
    drive(1, 0, 3, 0, 0, 0, 0, 0);
    next();
    drive(0, 0, 0, 0, 1, 0, 2, 0);
    @(negedge clk);
    chk("b2b_a_rdata", int'(bus.a_rdata), 5);
    next();
    drive(1, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    chk("b2b_b_rvalid", int'(bus.b_rvalid), 1);
    chk("b2b_b_rdata",  int'(bus.b_rdata),  7);
    next();
    idle();
    @(negedge clk);
    chk("b2b_a2_rdata", int'(bus.a_rdata), 0);
    chk("b2b_a2_rvalid", int'(bus.a_rvalid), 1);
    next();
    next();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
